// File: rtl/coef_load_ctrl.sv
// Coefficient load sequencer: streams DEPTH words from a valid/ready source
// into the FIR coefficient buffer write port, using 1-based write indices.
//
// state   | meaning
// IDLE    | waiting for start; buffer contents reported by coef_valid
// LOAD    | accepting words, one buffer write per handshake
// DONE    | last word written; pulse done and publish coef_valid
module coef_load_ctrl #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     s_valid,
  input  logic [WIDTH-1:0]         s_data,
  output logic                     s_ready,
  output logic                     load,
  output logic [$clog2(DEPTH):0]   loadidx,
  output logic [WIDTH-1:0]         datain,
  output logic                     busy,
  output logic                     done,
  output logic                     coef_valid
);

  localparam int IDXW = $clog2(DEPTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;
  logic             load_q, load_d;
  logic [IDXW-1:0]  loadidx_q, loadidx_d;
  logic [WIDTH-1:0] datain_q, datain_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             coef_valid_q, coef_valid_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_d       = 1'b0;
    loadidx_d    = '0;
    datain_d     = datain_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    coef_valid_d = coef_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d      = ST_LOAD;
          cnt_d        = IDX_ONE;
          busy_d       = 1'b1;
          coef_valid_d = 1'b0;
        end
      end

      ST_LOAD: begin
        // abort wins over a same-cycle handshake; that word is discarded
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (s_valid) begin
          load_d    = 1'b1;
          loadidx_d = cnt_q;
          datain_d  = s_data;
          if (cnt_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + IDX_ONE;
          end
        end
      end

      ST_DONE: begin
        // the final write lands at the end of this cycle, so the set is
        // complete exactly when done/coef_valid appear
        state_d      = ST_IDLE;
        done_d       = 1'b1;
        coef_valid_d = 1'b1;
        busy_d       = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      load_q       <= 1'b0;
      loadidx_q    <= '0;
      datain_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      coef_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      load_q       <= load_d;
      loadidx_q    <= loadidx_d;
      datain_q     <= datain_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      coef_valid_q <= coef_valid_d;
    end
  end

  assign s_ready    = (state_q == ST_LOAD);
  assign load       = load_q;
  assign loadidx    = loadidx_q;
  assign datain     = datain_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign coef_valid = coef_valid_q;

endmodule

// File: tb/tb_coef_load_ctrl.sv
// Directed bench for coef_load_ctrl: DEPTH=4 main instance plus DEPTH=1 and
// DEPTH=8 instances exercised together in a continuous-stream phase.
module tb_coef_load_ctrl;

  localparam int W = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, start_aux, abort, s_valid;
  logic [W-1:0] s_data;

  logic         s_ready4, load4, busy4, done4, cv4;
  logic [2:0]   idx4;
  logic [W-1:0] din4;
  logic         s_ready1, load1, busy1, done1, cv1;
  logic [0:0]   idx1;
  logic [W-1:0] din1;
  logic         s_ready8, load8, busy8, done8, cv8;
  logic [3:0]   idx8;
  logic [W-1:0] din8;

  coef_load_ctrl #(.WIDTH(W), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready4),
    .load(load4), .loadidx(idx4), .datain(din4),
    .busy(busy4), .done(done4), .coef_valid(cv4));

  coef_load_ctrl #(.WIDTH(W), .DEPTH(1)) u1 (
    .clk(clk), .reset(reset), .start(start_aux), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1),
    .load(load1), .loadidx(idx1), .datain(din1),
    .busy(busy1), .done(done1), .coef_valid(cv1));

  coef_load_ctrl #(.WIDTH(W), .DEPTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start_aux), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready8),
    .load(load8), .loadidx(idx8), .datain(din8),
    .busy(busy8), .done(done8), .coef_valid(cv8));

  // coefficient buffer model fed by the DEPTH=4 write port
  logic [W-1:0] mem [4];
  always @(posedge clk)
    if (load4 && idx4 >= 3'd1 && idx4 <= 3'd4) mem[idx4-3'd1] <= din4;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready4), 64'd0);
    chk({tag, "_load"},    64'(load4),    64'd0);
    chk({tag, "_loadidx"}, 64'(idx4),     64'd0);
    chk({tag, "_datain"},  64'(din4),     64'd0);
    chk({tag, "_busy"},    64'(busy4),    64'd0);
    chk({tag, "_done"},    64'(done4),    64'd0);
    chk({tag, "_cv"},      64'(cv4),      64'd0);
  endtask

  // start, four back-to-back words base+1..base+4, return in the done cycle
  task automatic full_load(input logic [W-1:0] base);
    start = 1'b1; s_valid = 1'b1; s_data = base + W'(1);
    tick();
    start = 1'b0;
    chk("fl_busy",   64'(busy4),    64'd1);
    chk("fl_ready",  64'(s_ready4), 64'd1);
    chk("fl_cv_clr", 64'(cv4),      64'd0);
    chk("fl_done0",  64'(done4),    64'd0);
    for (int k = 1; k <= 4; k++) begin
      s_data = base + W'(k);
      tick();
      chk("fl_load",   64'(load4), 64'd1);
      chk("fl_idx",    64'(idx4),  64'(k));
      chk("fl_datain", 64'(din4),  64'(base + W'(k)));
      chk("fl_nodone", 64'(done4), 64'd0);
    end
    s_valid = 1'b0;
    chk("fl_ready_done_st", 64'(s_ready4), 64'd0);
    tick();
    chk("fl_done",  64'(done4), 64'd1);
    chk("fl_cv",    64'(cv4),   64'd1);
    chk("fl_idle",  64'(busy4), 64'd0);
    chk("fl_load0", 64'(load4), 64'd0);
    chk("fl_idx0",  64'(idx4),  64'd0);
    for (int k = 0; k < 4; k++) chk("fl_buf", 64'(mem[k]), 64'(base + W'(k + 1)));
  endtask

  initial begin
    int pat [7];
    int hs;
    int dn;
    logic ld;

    reset = 1'b0; start = 1'b0; start_aux = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_data = '0;
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b1;
    tick();
    chk("rel_busy",  64'(busy4),    64'd0);
    chk("rel_ready", 64'(s_ready4), 64'd0);
    chk("rel_load",  64'(load4),    64'd0);

    // continuous stream: buffer ends as {4,3,2,1}
    full_load(W'(0));

    // bubbles, started back-to-back in the done cycle
    pat = '{1, 0, 0, 1, 1, 0, 1};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bb_busy",   64'(busy4), 64'd1);
    chk("bb_cv_clr", 64'(cv4),   64'd0);
    chk("bb_done0",  64'(done4), 64'd0);
    hs = 0;
    for (int i = 0; i < 7; i++) begin
      s_valid = pat[i][0];
      s_data  = W'('h200 + hs + 1);
      tick();
      if (pat[i] != 0) hs++;
      chk("bb_load", 64'(load4), 64'(pat[i]));
      chk("bb_idx",  64'(idx4),  (pat[i] != 0) ? 64'(hs) : 64'd0);
      if (pat[i] != 0) chk("bb_datain", 64'(din4), 64'('h200 + hs));
      chk("bb_nodone", 64'(done4), 64'd0);
    end
    s_valid = 1'b0;
    tick();
    chk("bb_done", 64'(done4), 64'd1);
    chk("bb_cv",   64'(cv4),   64'd1);
    chk("bb_buf3", 64'(mem[2]), 64'h203);
    tick();
    chk("bb_done_pulse", 64'(done4), 64'd0);
    chk("bb_cv_hold",    64'(cv4),   64'd1);

    // abort after two words; the word offered with abort is dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1; s_data = W'('h301);
    tick();
    s_data = W'('h302);
    tick();
    abort = 1'b1; s_data = W'('hDEAD);
    tick();
    abort = 1'b0; s_valid = 1'b0;
    chk("ab_busy",  64'(busy4),    64'd0);
    chk("ab_ready", 64'(s_ready4), 64'd0);
    chk("ab_load",  64'(load4),    64'd0);
    chk("ab_idx",   64'(idx4),     64'd0);
    chk("ab_cv",    64'(cv4),      64'd0);
    chk("ab_done",  64'(done4),    64'd0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done4) dn++;
    end
    chk("ab_nodone", 64'(dn), 64'd0);
    chk("ab_buf2",   64'(mem[1]), 64'h302);
    chk("ab_buf3",   64'(mem[2]), 64'h203);
    full_load(W'('h30));

    // async reset mid-load with cnt=3
    start = 1'b1; s_valid = 1'b1; s_data = W'('h501);
    tick();
    start = 1'b0;
    tick();
    s_data = W'('h502);
    tick();
    chk("ar_pre_idx", 64'(idx4), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("ar");
    tick();
    reset = 1'b1;
    s_data = W'('h5FF);
    tick();
    chk("ar_ready", 64'(s_ready4), 64'd0);
    chk("ar_load",  64'(load4),    64'd0);
    chk("ar_busy",  64'(busy4),    64'd0);
    full_load(W'('h60));

    // start pulses during LOAD and DONE are ignored
    tick();
    start = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      s_valid = 1'b1;
      s_data  = W'('h40 + k);
      start   = (k == 2);
      tick();
      chk("ig_load", 64'(load4), 64'd1);
      chk("ig_idx",  64'(idx4),  64'(k));
    end
    start = 1'b1; s_valid = 1'b1; s_data = W'('h4F);
    tick();
    start = 1'b0; s_valid = 1'b0;
    chk("ig_done",  64'(done4),    64'd1);
    chk("ig_ready", 64'(s_ready4), 64'd0);
    chk("ig_busy",  64'(busy4),    64'd0);
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done4) dn++;
    end
    chk("ig_extra_done", 64'(dn), 64'd0);
    chk("ig_idle",       64'(s_ready4), 64'd0);

    // DEPTH=1 and DEPTH=8 under continuous valid
    start_aux = 1'b1; s_valid = 1'b1; s_data = W'('h10);
    tick();
    start_aux = 1'b0;
    chk("d1_busy", 64'(busy1), 64'd1);
    chk("d8_busy", 64'(busy8), 64'd1);
    for (int c = 1; c <= 11; c++) begin
      s_data = W'('h10 + c);
      tick();
      ld = (c <= 1);
      chk("d1_load", 64'(load1), 64'(ld));
      chk("d1_idx",  64'(idx1),  ld ? 64'(c) : 64'd0);
      chk("d1_done", 64'(done1), 64'(c == 2));
      chk("d1_busy", 64'(busy1), 64'(ld));
      if (ld) chk("d1_datain", 64'(din1), 64'('h10 + c));
      ld = (c <= 8);
      chk("d8_load", 64'(load8), 64'(ld));
      chk("d8_idx",  64'(idx8),  ld ? 64'(c) : 64'd0);
      chk("d8_done", 64'(done8), 64'(c == 9));
      chk("d8_busy", 64'(busy8), 64'(ld));
      if (ld) chk("d8_datain", 64'(din8), 64'('h10 + c));
    end
    s_valid = 1'b0;
    chk("d1_cv", 64'(cv1), 64'd1);
    chk("d8_cv", 64'(cv8), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coef_load_ctrl.md
# coef_load_ctrl

Sequencer that fills the FIR coefficient buffer from a streaming configuration source. It accepts DEPTH coefficient words over a valid/ready handshake and drives the buffer's load/loadidx/datain write port with 1-based indices. It reports when a complete, consistent coefficient set is resident. It sits between the host/config interface and the coefficient buffer in the FIR clock domain.

## Interface
- WIDTH, 27, coefficient word width (matches buffer WIDTH)
- DEPTH, 4, number of coefficients (matches buffer DEPTH); DEPTH >= 1

- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  begin loading a new coefficient set (sampled in IDLE only)
- abort  in  1  cancel a load in progress
- s_valid  in  1  source has a coefficient word
- s_data  in  WIDTH  coefficient word, coefficient 0 first
- s_ready  out  1  controller accepts a word this cycle
- load  out  1  buffer write strobe
- loadidx  out  $clog2(DEPTH)+1  1-based buffer index; 0 = no write
- datain  out  WIDTH  word to write
- busy  out  1  load sequence in progress
- done  out  1  one-cycle pulse: full set written
- coef_valid  out  1  level: buffer holds a complete set from the last sequence

## Operation
- States: IDLE, LOAD, DONE. Internal counter cnt, width $clog2(DEPTH)+1, range 1..DEPTH.
- s_ready = (state == LOAD), decoded from the state register with no input dependency.
- A handshake is s_valid & s_ready.
- IDLE:
  - start=1 and abort=0 -> LOAD; cnt<=1, busy<=1, coef_valid<=0.
  - Otherwise hold.
- LOAD, abort=1: -> IDLE; busy<=0, load<=0, loadidx<=0. coef_valid stays 0 and no done is issued. Abort beats a same-cycle handshake; that beat is dropped.
- LOAD, handshake: load<=1, loadidx<=cnt, datain<=s_data.
  - cnt==DEPTH -> DONE.
  - Otherwise cnt<=cnt+1 and stay in LOAD.
- LOAD, no handshake: load<=0, loadidx<=0; datain holds.
- DONE, unconditional, one cycle: -> IDLE; done<=1, coef_valid<=1, busy<=0, load<=0, loadidx<=0. Abort and start are ignored in DONE.
- done deasserts the cycle after it is asserted.
- start is ignored while busy; it is not queued.
- cnt never exceeds DEPTH and never wraps. The loadidx bus always holds DEPTH (no truncation).
- DEPTH=1: a single handshake goes LOAD -> DONE.

## Timing
- Reset values, applied asynchronously on reset=0:
  - state=IDLE, cnt=0
  - s_ready=0, load=0, loadidx=0, datain=0
  - busy=0, done=0, coef_valid=0
- Reset asserted mid-load behaves as an abort, and coef_valid is also forced to 0. Release is synchronous to the next clk edge, with no outputs changing on release.
- start at edge E0 -> busy=1 and s_ready=1 from E0. The first handshake can complete at E1.
- Handshake at edge En -> load/loadidx/datain are valid for the cycle after En. The buffer writes at En+1.
- Last handshake at edge Ek: DONE during (Ek, Ek+1]. done=1 and coef_valid=1 during (Ek+1, Ek+2], which is the first cycle the buffer holds the full set.
- Minimum sequence: 1 + DEPTH + 1 cycles from start to done. With DEPTH=4 and continuous s_valid, start at cycle 0 gives done at cycle 6.
- Back-to-back: start may be asserted the cycle done is high; it is sampled in IDLE and clears coef_valid at the next edge.

## Test plan
- Continuous stream, DEPTH=4: start, then s_data 0x1,0x2,0x3,0x4 with s_valid=1 -> loadidx 1,2,3,4 on consecutive cycles with load=1 and datain matching. One done pulse, then coef_valid=1; buffer holds {4,3,2,1}.
- Bubbles: s_valid toggles 1,0,0,1,1,0,1 -> load and loadidx=0 on idle cycles, indices still 1..4 in order, done two cycles after the 4th handshake.
- Abort after 2 words: the abort cycle also presents a valid word -> that word is not written, state IDLE, busy=0, coef_valid=0, no done. A following full load completes normally.
- Async reset: assert reset=0 mid-edge during LOAD with cnt=3 -> all outputs reach reset values immediately. After release, start is required; the first write uses loadidx=1.
- Ignored start: pulse start during LOAD and during DONE -> no restart, indices continue, exactly one done.
- DEPTH=1 and DEPTH=8 builds: full load -> loadidx reaches DEPTH (1 and 8) without wrap; done timing is DEPTH+2 cycles after start under continuous valid.
